// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline carrying WIDTH-bit words.
// Empty stages always accept from upstream, so gaps close up while the output is stalled.
// Optional build macro PIPE_REG_CHAIN_PARITY_EN adds a per-stage parity bit and the
// out_par_err output.
module pipe_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_REG_CHAIN_PARITY_EN
    ,
    output logic                       out_par_err
`endif
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [DEPTH-1:0]            adv;   // stage i loads from upstream this cycle
    logic [DEPTH-1:0]            up_v;
    logic [DEPTH-1:0][WIDTH-1:0] up_d;
    logic [OW-1:0]               occ_q, occ_d;
    logic                        in_hs, out_hs;

    // Load enables: a stage can load when it is empty or its own word is leaving.
    // Built from the output end back to stage 0, so ready never depends on in_valid.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready | ~v_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~v_q[i];
        end
    end

    // Upstream source of each stage: the input port for stage 0, otherwise the previous stage.
    always_comb begin
        up_v = '0;
        up_d = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Stage next-state: data only moves with a valid word, so bubbles leave the data register alone.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i]) begin
                v_d[i] = up_v[i];
                if (up_v[i]) d_d[i] = up_d[i];
            end
        end
        if (flush) begin
            v_d = '0;
            d_d = {DEPTH{RESET_VAL}};
        end
    end

    // Occupancy tracks the handshakes; a simultaneous push and pop cancel out.
    always_comb begin
        occ_d = occ_q;
        if (in_hs && !out_hs)      occ_d = occ_q + OW'(1);
        else if (!in_hs && out_hs) occ_d = occ_q - OW'(1);
        if (flush) occ_d = '0;
    end

    // Stage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            d_q   <= {DEPTH{RESET_VAL}};
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

`ifdef PIPE_REG_CHAIN_PARITY_EN
    localparam logic RESET_PAR = ^RESET_VAL;

    logic [DEPTH-1:0] p_q, p_d, up_p;

    // Parity rides alongside the data and follows the same load rules.
    always_comb begin
        up_p = '0;
        up_p[0] = ^in_data;
        for (int i = 1; i < DEPTH; i++) up_p[i] = p_q[i-1];
        p_d = p_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i] && up_v[i]) p_d[i] = up_p[i];
        end
        if (flush) p_d = {DEPTH{RESET_PAR}};
    end

    // Parity registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) p_q <= {DEPTH{RESET_PAR}};
        else        p_q <= p_d;
    end

    assign out_par_err = out_valid & ((^out_data) ^ p_q[DEPTH-1]);
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (WIDTH=8, DEPTH=3, RESET_VAL=0).
// Stimulus pushes {expected parity error, data} on each accepted input; an
// independent monitor pops and compares on every output handshake.
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic       out_par_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_REG_CHAIN_PARITY_EN
        ,
        .out_par_err (out_par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding word.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
`ifdef PIPE_REG_CHAIN_PARITY_EN
                chk("out_par_err", {31'h0, out_par_err}, {31'h0, e[8]});
`endif
            end
        end
    end

    // Present a word until accepted (bounded); returns just after the accepting edge.
    task automatic push(input logic [7:0] dat);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = dat;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({1'b0, dat});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept expected accept of %0h", dat);
        end
    endtask

    // Drain with out_ready=1 until pipeline and scoreboard are empty (bounded).
    task automatic drain();
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (occupancy == 2'd0 && exp_q.size() == 0) ok = 1'b1;
        end
        chk("drain_done", {31'h0, ok}, 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held with a word offered: nothing may enter.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_occupancy", {30'h0, occupancy}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Latency: empty chain, out_ready high, word appears three cycles later.
        out_ready = 1'b1;
        push(8'h11);
        @(negedge clk);
        chk("lat_stage0", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_stage1", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_stage2", {31'h0, out_valid}, 32'h1);
        chk("lat_data", {24'h0, out_data}, 32'h11);
        @(posedge clk);
        #1;
        drain();

        // Throughput: back-to-back words, occupancy pinned at 3 once full.
        for (int k = 0; k < 8; k++) begin
            push(8'h11 + 8'(k));
            if (k >= 2) chk("b2b_occupancy", {30'h0, occupancy}, 32'd3);
        end
        drain();

        // Backpressure: three words fill the chain, fourth waits upstream.
        out_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("bp_occupancy", {30'h0, occupancy}, 32'd3);
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        fork
            push(8'h04);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_hold_ready", {31'h0, in_ready}, 32'h0);
                    chk("bp_hold_data", {24'h0, out_data}, 32'h01);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Bubble collapse: two words separated by idle cycles pack against the stalled output.
        out_ready = 1'b0;
        push(8'hA1);
        idle(2);
        push(8'hA2);
        idle(2);
        chk("bub_occupancy", {30'h0, occupancy}, 32'd2);
        chk("bub_in_ready", {31'h0, in_ready}, 32'h1);
        chk("bub_out_valid", {31'h0, out_valid}, 32'h1);
        chk("bub_out_data", {24'h0, out_data}, 32'hA1);
        drain();

        // Flush with a concurrent input handshake: B1 leaves legally, B2/B3/C4 vanish.
        out_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        chk("fl_full", {30'h0, occupancy}, 32'd3);
        in_valid  = 1'b1;
        in_data   = 8'hC4;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("fl_occupancy", {30'h0, occupancy}, 32'h0);
        chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
        chk("fl_out_data", {24'h0, out_data}, 32'h0);
        idle(6);

        // Reset in the middle of a transfer discards everything.
        out_ready = 1'b0;
        push(8'hD1);
        push(8'hD2);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_occupancy", {30'h0, occupancy}, 32'h0);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        idle(5);
        push(8'h5A);
        drain();

`ifdef PIPE_REG_CHAIN_PARITY_EN
        // Parity: corrupt the word while it sits in stage 1.
        out_ready = 1'b0;
        push(8'h07);
        @(posedge clk);
        #1;
        force dut.d_q[1] = 8'h06;
        @(posedge clk);
        #1;
        release dut.d_q[1];
        exp_q[exp_q.size()-1] = {1'b1, 8'h06};
        push(8'h55);
        drain();
`endif

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
